// File: rtl/divider_taint_track_if.sv
// Request/result bundle for divider_taint_track.
//
// Groups the operand inputs, their taint shadows and the result outputs (with taint
// shadows) of the taint-tracked restoring divider. Clock and reset stay outside.
//   master : the requester; drives start/operands, observes results
//   slave  : the divider; observes start/operands, drives results
interface divider_taint_track_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] dividend_t;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] divisor_t;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] quotient_t;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] remainder_t;
  logic             quotientDone;
  logic             quotientDone_t;
  logic             divByZero;

  modport master (
    output start, start_t, dividend, dividend_t, divisor, divisor_t,
    input  quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t, divByZero
  );

  modport slave (
    input  start, start_t, dividend, dividend_t, divisor, divisor_t,
    output quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t, divByZero
  );
endinterface

// File: rtl/divider_taint_track.sv
// Sequential restoring divider with bit-level taint tracking.
//
// Computes quotient and remainder of two unsigned WIDTH-bit operands, one quotient bit per
// cycle, MSB first. Every result carries a shadow _t vector marking bits that may depend on
// tainted inputs; untainted inputs always produce all-zero result taints.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any operation, clears all outputs)
//   bus  : divider_taint_track_if.slave
//          start/start_t, dividend/_t, divisor/_t         -> sampled on an accepted start (IDLE)
//          quotient/_t, remainder/_t, divByZero           -> registered, held until next completion
//          quotientDone/_t                                -> one-cycle completion pulse
//
// Optional feature macro: DIV_EARLY_ZERO_EN
//   defined   : a zero divisor skips the iterations (IDLE -> DONE), same values and taints
//   undefined : a zero divisor runs the full WIDTH iterations
module divider_taint_track #(
  parameter int unsigned WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  divider_taint_track_if.slave    bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Dividend shift register: its MSB feeds the accumulator each iteration.
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvd_t_q, dvd_t_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  dvs_t_q, dvs_t_d;
  // Partial remainder. After the restore step it is always below the divisor, so WIDTH bits
  // suffice for storage; the shifted value used for compare is WIDTH+1 bits.
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  acc_t_q, acc_t_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  quot_t_q, quot_t_d;
  logic              ctl_t_q, ctl_t_d;
  logic              zero_q, zero_d;

  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  quotient_t_q, quotient_t_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic [WIDTH-1:0]  remainder_t_q, remainder_t_d;
  logic              done_q, done_d;
  logic              done_t_q, done_t_d;
  logic              div_by_zero_q, div_by_zero_d;

  // Iteration datapath.
  logic [WIDTH:0]    acc_sh;
  logic [WIDTH:0]    acc_t_sh;
  logic              cmp_ge;
  logic              cmp_t;

  always_comb begin
    acc_sh   = {acc_q, dvd_q[WIDTH-1]};
    acc_t_sh = {acc_t_q, dvd_t_q[WIDTH-1]};
    cmp_ge   = (acc_sh >= {1'b0, dvs_q});
    // Compare outcome is tainted if any bit feeding it is tainted.
    cmp_t    = (|acc_t_sh) | (|dvs_t_q);
  end

`ifdef DIV_EARLY_ZERO_EN
  // Closed form of the full-run taints for a zero divisor: every iteration subtracts, so the
  // quotient taint of bit j is set once any tainted bit has been shifted in (dividend bits
  // WIDTH-1 down to j) or the divisor is tainted; the remainder taint saturates if anything
  // was ever tainted.
  logic [WIDTH-1:0] ez_quot_t;
  logic [WIDTH-1:0] ez_rem_t;
  logic             ez_run;

  always_comb begin
    ez_quot_t = '0;
    ez_run    = |bus.divisor_t;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      ez_run       = ez_run | bus.dividend_t[i];
      ez_quot_t[i] = ez_run;
    end
    ez_rem_t = ez_run ? '1 : '0;
  end
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    dvd_t_d       = dvd_t_q;
    dvs_d         = dvs_q;
    dvs_t_d       = dvs_t_q;
    acc_d         = acc_q;
    acc_t_d       = acc_t_q;
    quot_d        = quot_q;
    quot_t_d      = quot_t_q;
    ctl_t_d       = ctl_t_q;
    zero_d        = zero_q;
    quotient_d    = quotient_q;
    quotient_t_d  = quotient_t_q;
    remainder_d   = remainder_q;
    remainder_t_d = remainder_t_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;
    done_t_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d    = bus.dividend;
          dvd_t_d  = bus.dividend_t;
          dvs_d    = bus.divisor;
          dvs_t_d  = bus.divisor_t;
          ctl_t_d  = bus.start_t;
          zero_d   = (bus.divisor == '0);
          acc_d    = '0;
          acc_t_d  = '0;
          quot_d   = '0;
          quot_t_d = '0;
          cnt_d    = '0;
          state_d  = StIter;
`ifdef DIV_EARLY_ZERO_EN
          if (bus.divisor == '0) begin
            quot_d   = '1;
            quot_t_d = ez_quot_t;
            acc_d    = bus.dividend;
            acc_t_d  = ez_rem_t;
            state_d  = StDone;
          end
`endif
        end
      end

      StIter: begin
        dvd_d   = dvd_q << 1;
        dvd_t_d = dvd_t_q << 1;
        // True difference fits WIDTH bits whenever cmp_ge holds, so modular subtraction is exact.
        acc_d   = cmp_ge ? (acc_sh[WIDTH-1:0] - dvs_q) : acc_sh[WIDTH-1:0];
        acc_t_d = acc_t_sh[WIDTH-1:0] | (cmp_ge ? dvs_t_q : '0) | {WIDTH{cmp_t}};
        quot_d   = {quot_q[WIDTH-2:0], cmp_ge};
        quot_t_d = {quot_t_q[WIDTH-2:0], cmp_t};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end

      StDone: begin
        quotient_d    = quot_q;
        remainder_d   = acc_q;
        quotient_t_d  = ctl_t_q ? '1 : quot_t_q;
        remainder_t_d = ctl_t_q ? '1 : acc_t_q;
        div_by_zero_d = zero_q;
        done_d        = 1'b1;
        done_t_d      = ctl_t_q;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvd_t_q       <= '0;
      dvs_q         <= '0;
      dvs_t_q       <= '0;
      acc_q         <= '0;
      acc_t_q       <= '0;
      quot_q        <= '0;
      quot_t_q      <= '0;
      ctl_t_q       <= 1'b0;
      zero_q        <= 1'b0;
      quotient_q    <= '0;
      quotient_t_q  <= '0;
      remainder_q   <= '0;
      remainder_t_q <= '0;
      done_q        <= 1'b0;
      done_t_q      <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      dvd_t_q       <= dvd_t_d;
      dvs_q         <= dvs_d;
      dvs_t_q       <= dvs_t_d;
      acc_q         <= acc_d;
      acc_t_q       <= acc_t_d;
      quot_q        <= quot_d;
      quot_t_q      <= quot_t_d;
      ctl_t_q       <= ctl_t_d;
      zero_q        <= zero_d;
      quotient_q    <= quotient_d;
      quotient_t_q  <= quotient_t_d;
      remainder_q   <= remainder_d;
      remainder_t_q <= remainder_t_d;
      done_q        <= done_d;
      done_t_q      <= done_t_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign bus.quotient       = quotient_q;
  assign bus.quotient_t     = quotient_t_q;
  assign bus.remainder      = remainder_q;
  assign bus.remainder_t    = remainder_t_q;
  assign bus.quotientDone   = done_q;
  assign bus.quotientDone_t = done_t_q;
  assign bus.divByZero      = div_by_zero_q;

endmodule

// File: tb/tb_divider_taint_track.sv
module tb_divider_taint_track;
  localparam int unsigned W = 8;

`ifdef DIV_EARLY_ZERO_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  divider_taint_track_if #(.WIDTH(W)) bus ();

  divider_taint_track #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for its done pulse; lat = edges after E0, or -1.
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvd_t,
                        input logic [W-1:0] dvs, input logic [W-1:0] dvs_t,
                        input logic st, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.start_t = st;
    bus.dividend = dvd; bus.dividend_t = dvd_t;
    bus.divisor = dvs; bus.divisor_t = dvs_t;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.start_t = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.quotientDone === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.quotient !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", bus.quotient); end
    total++; if (bus.remainder !== 8'h00) begin bad++; $display("FAIL reset_r got=%h want=00", bus.remainder); end
    total++; if ({bus.quotient_t, bus.remainder_t} !== 16'h0000) begin bad++; $display("FAIL reset_taint got=%h want=0000", {bus.quotient_t, bus.remainder_t}); end
    total++; if ({bus.quotientDone, bus.quotientDone_t, bus.divByZero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.quotientDone, bus.quotientDone_t, bus.divByZero}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    run_op(8'd100, 8'h00, 8'd7, 8'h00, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_lat got=%0d want=9", lat); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL basic_q got=%0d want=14", bus.quotient); end
    total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL basic_r got=%0d want=2", bus.remainder); end
    total++; if ({bus.quotient_t, bus.remainder_t, bus.quotientDone_t} !== 17'h0) begin bad++; $display("FAIL basic_taint got=%h want=0", {bus.quotient_t, bus.remainder_t, bus.quotientDone_t}); end
    total++; if (bus.divByZero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", bus.divByZero); end
    @(posedge clk); #1;
    total++; if (bus.quotientDone !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0", bus.quotientDone); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL basic_hold got=%0d want=14", bus.quotient); end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(8'd37, 8'h00, 8'd0, 8'h00, 1'b0, lat);
    total++; if (lat !== ZeroLat) begin bad++; $display("FAIL dz_lat got=%0d want=%0d", lat, ZeroLat); end
    total++; if (bus.quotient !== 8'hFF) begin bad++; $display("FAIL dz_q got=%h want=ff", bus.quotient); end
    total++; if (bus.remainder !== 8'd37) begin bad++; $display("FAIL dz_r got=%0d want=37", bus.remainder); end
    total++; if (bus.divByZero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", bus.divByZero); end
    total++; if ({bus.quotient_t, bus.remainder_t} !== 16'h0000) begin bad++; $display("FAIL dz_taint got=%h want=0000", {bus.quotient_t, bus.remainder_t}); end
    @(posedge clk); #1;
    total++; if ({bus.quotientDone, bus.divByZero} !== 2'b01) begin bad++; $display("FAIL dz_hold got=%b want=01", {bus.quotientDone, bus.divByZero}); end
  endtask

  task automatic test_dividend_taint;
    int lat;
    run_op(8'd200, 8'h01, 8'd5, 8'h00, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL dt_lat got=%0d want=9", lat); end
    total++; if ({bus.quotient, bus.remainder} !== {8'd40, 8'd0}) begin bad++; $display("FAIL dt_qr got=%h want=2800", {bus.quotient, bus.remainder}); end
    total++; if (bus.quotient_t !== 8'h01) begin bad++; $display("FAIL dt_qt got=%h want=01", bus.quotient_t); end
    total++; if (bus.remainder_t !== 8'hFF) begin bad++; $display("FAIL dt_rt got=%h want=ff", bus.remainder_t); end
    total++; if ({bus.quotientDone_t, bus.divByZero} !== 2'b00) begin bad++; $display("FAIL dt_flags got=%b want=00", {bus.quotientDone_t, bus.divByZero}); end
  endtask

  task automatic test_divisor_taint;
    int lat;
    run_op(8'd100, 8'h00, 8'd7, 8'h80, 1'b0, lat);
    total++; if ({bus.quotient, bus.remainder} !== {8'd14, 8'd2}) begin bad++; $display("FAIL vt_qr got=%h want=0e02", {bus.quotient, bus.remainder}); end
    total++; if ({bus.quotient_t, bus.remainder_t} !== 16'hFFFF) begin bad++; $display("FAIL vt_taint got=%h want=ffff", {bus.quotient_t, bus.remainder_t}); end
    total++; if (bus.quotientDone_t !== 1'b0) begin bad++; $display("FAIL vt_done_t got=%b want=0", bus.quotientDone_t); end
  endtask

  task automatic test_control_taint;
    int lat;
    run_op(8'd50, 8'h00, 8'd3, 8'h00, 1'b1, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL ct_lat got=%0d want=9", lat); end
    total++; if ({bus.quotient, bus.remainder} !== {8'd16, 8'd2}) begin bad++; $display("FAIL ct_qr got=%h want=1002", {bus.quotient, bus.remainder}); end
    total++; if ({bus.quotient_t, bus.remainder_t} !== 16'hFFFF) begin bad++; $display("FAIL ct_taint got=%h want=ffff", {bus.quotient_t, bus.remainder_t}); end
    total++; if (bus.quotientDone_t !== 1'b1) begin bad++; $display("FAIL ct_done_t got=%b want=1", bus.quotientDone_t); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1; bus.start_t = 1'b0;
    bus.dividend = 8'd255; bus.dividend_t = 8'h00; bus.divisor = 8'd16; bus.divisor_t = 8'h00;
    @(posedge clk);                       // E0
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);            // E0+3
    #1 rst = 1'b1;
    @(posedge clk);                       // E0+4: abort
    #1;
    total++; if ({bus.quotient, bus.remainder} !== 16'h0000) begin bad++; $display("FAIL rst_mid_qr got=%h want=0000", {bus.quotient, bus.remainder}); end
    total++; if ({bus.quotient_t, bus.remainder_t, bus.quotientDone_t} !== 17'h0) begin bad++; $display("FAIL rst_mid_taint got=%h want=0", {bus.quotient_t, bus.remainder_t, bus.quotientDone_t}); end
    // rst and start together on the next edge: start must be dropped.
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd9;
    @(posedge clk);
    #1 rst = 1'b0; bus.start = 1'b0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (bus.quotientDone === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_no_pulse got=%0d want=0", pulses); end
    run_op(8'd9, 8'h00, 8'd9, 8'h00, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL rst_next_lat got=%0d want=9", lat); end
    total++; if ({bus.quotient, bus.remainder} !== {8'd1, 8'd0}) begin bad++; $display("FAIL rst_next_qr got=%h want=0100", {bus.quotient, bus.remainder}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int pulses;
    int first;
    @(negedge clk);
    bus.start = 1'b1; bus.start_t = 1'b0;
    bus.dividend = 8'd100; bus.dividend_t = 8'h00; bus.divisor = 8'd7; bus.divisor_t = 8'h00;
    @(posedge clk);                       // E0, start stays high through ITER
    pulses = 0;
    first = -1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (bus.quotientDone === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n;
          total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL b2b_q got=%0d want=14", bus.quotient); end
        end
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d want=1", pulses); end
    total++; if (first !== 9) begin bad++; $display("FAIL b2b_lat got=%0d want=9", first); end
    run_op(8'd200, 8'h00, 8'd5, 8'h00, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL b2b_next_lat got=%0d want=9", lat); end
    total++; if ({bus.quotient, bus.remainder} !== {8'd40, 8'd0}) begin bad++; $display("FAIL b2b_next_qr got=%h want=2800", {bus.quotient, bus.remainder}); end
  endtask

  initial begin
    bus.start = 1'b0; bus.start_t = 1'b0;
    bus.dividend = '0; bus.dividend_t = '0; bus.divisor = '0; bus.divisor_t = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_dividend_taint();
    test_divisor_taint();
    test_control_taint();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
